// File: rtl/reg_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : reg_scoreboard
// Description : Register-pending scoreboard beside ID; tracks in-flight writes
//               per register and produces the ID stall / accept decision.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_scoreboard #(
    parameter int CNT_W = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mode,
    input  logic        issue_valid,
    input  logic        issue_wb_en,
    input  logic        issue_mem_r_en,
    input  logic [3:0]  issue_dest,
    input  logic [3:0]  src1,
    input  logic [3:0]  src2,
    input  logic        two_src,
    input  logic        flush,
    input  logic        wb_en,
    input  logic [3:0]  wb_dest,
    output logic        hazard_detected,
    output logic        issue_accept,
    output logic [15:0] pending_mask,
    output logic        sb_error
);

    localparam logic [CNT_W-1:0] c_cnt_max  = '1;
    localparam logic [CNT_W-1:0] c_cnt_zero = '0;
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

    logic [CNT_W-1:0] r_cnt [16];
    logic             r_ld_valid;
    logic [3:0]       r_ld_dest;
    logic             r_err;

    logic [15:0]      w_pend;
    logic             w_hz_m0;
    logic             w_hz_m1;
    logic             w_ovf;
    logic             w_ovf_retire;

    // A register retiring this cycle with its last outstanding write is
    // treated as ready: the register file writes through.
    generate
        for (genvar i = 0; i < 16; i++) begin : g_cnt
            logic w_hit_wb;
            logic w_inc;
            logic w_dec;

            assign w_hit_wb        = wb_en && (wb_dest == 4'(i));
            assign w_pend[i]       = (r_cnt[i] != c_cnt_zero) &&
                                     !(w_hit_wb && (r_cnt[i] == c_cnt_one));
            assign pending_mask[i] = (r_cnt[i] != c_cnt_zero);
            assign w_inc           = issue_accept && issue_wb_en && (issue_dest == 4'(i));
            assign w_dec           = w_hit_wb && (r_cnt[i] != c_cnt_zero);

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_cnt[i] <= c_cnt_zero;
                end else if (w_inc && !w_dec) begin
                    r_cnt[i] <= r_cnt[i] + c_cnt_one;
                end else if (w_dec && !w_inc) begin
                    r_cnt[i] <= r_cnt[i] - c_cnt_one;
                end
            end
        end
    endgenerate

    always_comb begin
        w_hz_m0      = issue_valid && (w_pend[src1] || (two_src && w_pend[src2]));
        w_hz_m1      = issue_valid && r_ld_valid &&
                       ((src1 == r_ld_dest) || (two_src && (src2 == r_ld_dest)));
        w_ovf_retire = wb_en && (wb_dest == issue_dest);
        // Saturated counter cannot take another write unless one drains now.
        w_ovf        = issue_valid && issue_wb_en &&
                       (r_cnt[issue_dest] == c_cnt_max) && !w_ovf_retire;
        hazard_detected = (mode ? w_hz_m1 : w_hz_m0) || w_ovf;
        issue_accept    = issue_valid && !hazard_detected && !flush;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ld_valid <= 1'b0;
            r_ld_dest  <= 4'd0;
            r_err      <= 1'b0;
        end else begin
            r_ld_valid <= issue_accept && issue_mem_r_en && issue_wb_en;
            r_ld_dest  <= issue_dest;
            if (wb_en && (r_cnt[wb_dest] == c_cnt_zero)) begin
                r_err <= 1'b1;
            end
        end
    end

    assign sb_error = r_err;

endmodule
`default_nettype wire

// File: tb/tb_reg_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_scoreboard
// Description : Directed self-checking bench for reg_scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_scoreboard;

    logic        clk;
    logic        rst;
    logic        mode;
    logic        issue_valid;
    logic        issue_wb_en;
    logic        issue_mem_r_en;
    logic [3:0]  issue_dest;
    logic [3:0]  src1;
    logic [3:0]  src2;
    logic        two_src;
    logic        flush;
    logic        wb_en;
    logic [3:0]  wb_dest;
    logic        hazard_detected;
    logic        issue_accept;
    logic [15:0] pending_mask;
    logic        sb_error;

    int n_checks = 0;
    int n_fail   = 0;

    reg_scoreboard #(.CNT_W(2)) dut (
        .clk             (clk),
        .rst             (rst),
        .mode            (mode),
        .issue_valid     (issue_valid),
        .issue_wb_en     (issue_wb_en),
        .issue_mem_r_en  (issue_mem_r_en),
        .issue_dest      (issue_dest),
        .src1            (src1),
        .src2            (src2),
        .two_src         (two_src),
        .flush           (flush),
        .wb_en           (wb_en),
        .wb_dest         (wb_dest),
        .hazard_detected (hazard_detected),
        .issue_accept    (issue_accept),
        .pending_mask    (pending_mask),
        .sb_error        (sb_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        issue_valid    = 1'b0;
        issue_wb_en    = 1'b0;
        issue_mem_r_en = 1'b0;
        issue_dest     = 4'd0;
        src1           = 4'd0;
        src2           = 4'd0;
        two_src        = 1'b0;
        flush          = 1'b0;
        wb_en          = 1'b0;
        wb_dest        = 4'd0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_write(input logic [3:0] d);
        issue_valid = 1'b1;
        issue_wb_en = 1'b1;
        issue_dest  = d;
    endtask

    task automatic test_reset();
        idle();
        mode = 1'b0;
        rst  = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        n_checks++;
        if (pending_mask !== 16'h0000) begin
            n_fail++; $display("FAIL reset_mask: got %h expected 0000", pending_mask);
        end
        n_checks++;
        if (sb_error !== 1'b0) begin
            n_fail++; $display("FAIL reset_err: got %b expected 0", sb_error);
        end
        n_checks++;
        if (hazard_detected !== 1'b0) begin
            n_fail++; $display("FAIL reset_hazard: got %b expected 0", hazard_detected);
        end
        issue_valid = 1'b1;
        #1;
        n_checks++;
        if (issue_accept !== 1'b1) begin
            n_fail++; $display("FAIL reset_accept: got %b expected 1", issue_accept);
        end
        idle();
    endtask

    task automatic test_issue_retire();
        issue_write(4'd3);
        #1;
        n_checks++;
        if (issue_accept !== 1'b1) begin
            n_fail++; $display("FAIL ir_accept: got %b expected 1", issue_accept);
        end
        tick();
        idle();
        n_checks++;
        if (pending_mask !== 16'h0008) begin
            n_fail++; $display("FAIL ir_mask_set: got %h expected 0008", pending_mask);
        end
        wb_en   = 1'b1;
        wb_dest = 4'd3;
        tick();
        idle();
        n_checks++;
        if (pending_mask !== 16'h0000) begin
            n_fail++; $display("FAIL ir_mask_clr: got %h expected 0000", pending_mask);
        end
    endtask

    task automatic test_mode0_stall();
        mode = 1'b0;
        issue_write(4'd3);
        tick();
        idle();
        issue_valid = 1'b1;
        src1        = 4'd3;
        for (int k = 0; k < 2; k++) begin
            #1;
            n_checks++;
            if (hazard_detected !== 1'b1 || issue_accept !== 1'b0) begin
                n_fail++;
                $display("FAIL m0_stall[%0d]: got hz=%b acc=%b expected hz=1 acc=0",
                         k, hazard_detected, issue_accept);
            end
            tick();
        end
        wb_en   = 1'b1;
        wb_dest = 4'd3;
        #1;
        n_checks++;
        if (hazard_detected !== 1'b0 || issue_accept !== 1'b1) begin
            n_fail++;
            $display("FAIL m0_release: got hz=%b acc=%b expected hz=0 acc=1",
                     hazard_detected, issue_accept);
        end
        tick();
        idle();
        n_checks++;
        if (pending_mask !== 16'h0000) begin
            n_fail++; $display("FAIL m0_mask: got %h expected 0000", pending_mask);
        end
    endtask

    task automatic test_two_src();
        mode = 1'b0;
        issue_write(4'd3);
        tick();
        idle();
        issue_valid = 1'b1;
        src1        = 4'd4;
        src2        = 4'd3;
        two_src     = 1'b0;
        #1;
        n_checks++;
        if (hazard_detected !== 1'b0) begin
            n_fail++; $display("FAIL two_src0: got %b expected 0", hazard_detected);
        end
        two_src = 1'b1;
        #1;
        n_checks++;
        if (hazard_detected !== 1'b1) begin
            n_fail++; $display("FAIL two_src1: got %b expected 1", hazard_detected);
        end
        idle();
        wb_en   = 1'b1;
        wb_dest = 4'd3;
        tick();
        idle();
    endtask

    task automatic test_mode1_load();
        mode = 1'b1;
        issue_write(4'd5);
        issue_mem_r_en = 1'b1;
        #1;
        n_checks++;
        if (issue_accept !== 1'b1) begin
            n_fail++; $display("FAIL m1_load_acc: got %b expected 1", issue_accept);
        end
        tick();
        idle();
        issue_valid = 1'b1;
        src1        = 4'd0;
        src2        = 4'd5;
        two_src     = 1'b1;
        #1;
        n_checks++;
        if (hazard_detected !== 1'b1 || issue_accept !== 1'b0) begin
            n_fail++;
            $display("FAIL m1_loaduse: got hz=%b acc=%b expected hz=1 acc=0",
                     hazard_detected, issue_accept);
        end
        tick();
        n_checks++;
        if (hazard_detected !== 1'b0 || issue_accept !== 1'b1) begin
            n_fail++;
            $display("FAIL m1_after: got hz=%b acc=%b expected hz=0 acc=1",
                     hazard_detected, issue_accept);
        end
        tick();
        idle();
        wb_en   = 1'b1;
        wb_dest = 4'd5;
        tick();
        idle();
        issue_write(4'd5);
        tick();
        idle();
        issue_valid = 1'b1;
        src2        = 4'd5;
        two_src     = 1'b1;
        #1;
        n_checks++;
        if (hazard_detected !== 1'b0) begin
            n_fail++; $display("FAIL m1_nonload: got %b expected 0", hazard_detected);
        end
        idle();
        wb_en   = 1'b1;
        wb_dest = 4'd5;
        tick();
        idle();
        n_checks++;
        if (pending_mask !== 16'h0000) begin
            n_fail++; $display("FAIL m1_mask: got %h expected 0000", pending_mask);
        end
        mode = 1'b0;
    endtask

    task automatic test_overflow();
        mode = 1'b0;
        issue_write(4'd7);
        tick();
        tick();
        tick();
        n_checks++;
        if (pending_mask !== 16'h0080) begin
            n_fail++; $display("FAIL ovf_mask: got %h expected 0080", pending_mask);
        end
        n_checks++;
        if (hazard_detected !== 1'b1 || issue_accept !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_stall: got hz=%b acc=%b expected hz=1 acc=0",
                     hazard_detected, issue_accept);
        end
        wb_en   = 1'b1;
        wb_dest = 4'd7;
        #1;
        n_checks++;
        if (hazard_detected !== 1'b0 || issue_accept !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_retire: got hz=%b acc=%b expected hz=0 acc=1",
                     hazard_detected, issue_accept);
        end
        tick();
        wb_en = 1'b0;
        #1;
        n_checks++;
        if (hazard_detected !== 1'b1) begin
            n_fail++; $display("FAIL ovf_still_full: got %b expected 1", hazard_detected);
        end
        idle();
        wb_en   = 1'b1;
        wb_dest = 4'd7;
        tick();
        tick();
        n_checks++;
        if (pending_mask !== 16'h0080) begin
            n_fail++; $display("FAIL ovf_drain2: got %h expected 0080", pending_mask);
        end
        tick();
        idle();
        n_checks++;
        if (pending_mask !== 16'h0000 || sb_error !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_drain3: got mask=%h err=%b expected mask=0000 err=0",
                     pending_mask, sb_error);
        end
    endtask

    task automatic test_error_flush();
        wb_en   = 1'b1;
        wb_dest = 4'd9;
        tick();
        idle();
        n_checks++;
        if (sb_error !== 1'b1 || pending_mask !== 16'h0000) begin
            n_fail++;
            $display("FAIL err_set: got err=%b mask=%h expected err=1 mask=0000",
                     sb_error, pending_mask);
        end
        tick();
        n_checks++;
        if (sb_error !== 1'b1) begin
            n_fail++; $display("FAIL err_sticky: got %b expected 1", sb_error);
        end
        issue_write(4'd2);
        flush = 1'b1;
        #1;
        n_checks++;
        if (issue_accept !== 1'b0) begin
            n_fail++; $display("FAIL flush_acc: got %b expected 0", issue_accept);
        end
        tick();
        idle();
        n_checks++;
        if (pending_mask !== 16'h0000) begin
            n_fail++; $display("FAIL flush_mask: got %h expected 0000", pending_mask);
        end
    endtask

    task automatic test_rst_mid();
        issue_write(4'd4);
        tick();
        idle();
        n_checks++;
        if (pending_mask !== 16'h0010) begin
            n_fail++; $display("FAIL rm_pre: got %h expected 0010", pending_mask);
        end
        rst = 1'b1;
        issue_write(4'd1);
        issue_mem_r_en = 1'b1;
        wb_en          = 1'b1;
        wb_dest        = 4'd12;
        tick();
        rst = 1'b0;
        idle();
        n_checks++;
        if (pending_mask !== 16'h0000 || sb_error !== 1'b0) begin
            n_fail++;
            $display("FAIL rm_post: got mask=%h err=%b expected mask=0000 err=0",
                     pending_mask, sb_error);
        end
        mode        = 1'b1;
        issue_valid = 1'b1;
        src1        = 4'd1;
        #1;
        n_checks++;
        if (hazard_detected !== 1'b0 || issue_accept !== 1'b1) begin
            n_fail++;
            $display("FAIL rm_ld: got hz=%b acc=%b expected hz=0 acc=1",
                     hazard_detected, issue_accept);
        end
        idle();
        mode = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        test_reset();
        test_issue_retire();
        test_mode0_stall();
        test_two_src();
        test_mode1_load();
        test_overflow();
        test_error_flush();
        test_rst_mid();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
